vga_timing_gen: RTL

//   Source end of the pixel-scan interface consumed by block_controller-style renderers.

---
 rtl/vga_timing_gen_pkg.sv | 41 ++++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen_clk_en_div.sv | 29 ++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, scan types and a window-decode helper used by the
// timing generator, renderers and ROM address logic.
package vga_timing_gen_pkg;

   localparam int CNT_W = 10;

   // Standard 640x480@60 timing, 25 MHz pixel clock from a 100 MHz master clock.
   localparam int CLK_DIV_DEF  = 4;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;

   localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;  // 800
   localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;  // 525

   // Visible-area origin and last visible pixel, for renderers: (144,35)..(783,514).
   localparam int H_VIS_LO_DEF = H_SYNC_DEF + H_BP_DEF;
   localparam int H_VIS_HI_DEF = H_VIS_LO_DEF + H_ACTIVE_DEF - 1;
   localparam int V_VIS_LO_DEF = V_SYNC_DEF + V_BP_DEF;
   localparam int V_VIS_HI_DEF = V_VIS_LO_DEF + V_ACTIVE_DEF - 1;

   typedef logic [CNT_W-1:0] cnt_t;

   // Registered per-pixel decode; sync fields are already active-low.
   typedef struct packed {
      logic bright;
      logic h_sync;
      logic v_sync;
   } scan_flags_t;

   // Inclusive window test on an unsigned count.
   function automatic logic in_window(cnt_t val, int lo, int hi);
      return (int'(val) >= lo) && (int'(val) <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-scan interface: the timing generator drives it, rgb producers listen.
interface vga_timing_gen_if;
   import vga_timing_gen_pkg::*;

   logic pix_en;
   cnt_t hCount;
   cnt_t vCount;
   logic bright;
   logic hSync;
   logic vSync;
   logic line_tick;
   logic frame_tick;

   modport master (
      output pix_en, hCount, vCount, bright, hSync, vSync, line_tick, frame_tick
   );

   modport slave (
      input  pix_en, hCount, vCount, bright, hSync, vSync, line_tick, frame_tick
   );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Strobe divider: one-clock enable every DIV clocks, first strobe DIV clocks after
// reset release. Also reused for slow movement enables driven off frame_tick.
module vga_timing_gen_clk_en_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic en
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] div_cnt;

   // Free-running 0..DIV-1 counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_cnt <= '0;
      else if (div_cnt == LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Strobe is a pure decode of the last count, so it is low whenever div_cnt is reset.
   assign en = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate strobe, h/v scan counters and registered
// sync/bright/tick decode. All decode is taken from next-state counts so every
// flag lines up with the counts currently on the ports.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   vga_timing_gen_if.master  scan
);

   localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int H_VIS_LO = H_SYNC + H_BP;
   localparam int H_VIS_HI = H_VIS_LO + H_ACTIVE - 1;
   localparam int V_VIS_LO = V_SYNC + V_BP;
   localparam int V_VIS_HI = V_VIS_LO + V_ACTIVE - 1;

   localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

   logic        pix_en;
   cnt_t        h_cnt, v_cnt;
   cnt_t        h_nxt, v_nxt;
   logic        h_wrap, v_wrap;
   scan_flags_t flags, flags_nxt;
   logic        line_tick, frame_tick;

   vga_timing_gen_clk_en_div #(.DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en)
   );

   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   // Next-state scan position; vertical only moves on a horizontal wrap.
   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (pix_en) begin
         h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
         if (h_wrap)
            v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
      end
   end

   // Scan counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
      end
   end

   // Decode from the next-state counts so the registered flags have zero skew.
   always_comb begin
      flags_nxt        = '0;
      flags_nxt.h_sync = ~(h_nxt < cnt_t'(H_SYNC));
      flags_nxt.v_sync = ~(v_nxt < cnt_t'(V_SYNC));
      flags_nxt.bright = in_window(h_nxt, H_VIS_LO, H_VIS_HI) &&
                         in_window(v_nxt, V_VIS_LO, V_VIS_HI);
   end

   // Registered flags and one-clock ticks marking the line/frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags      <= '0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         flags      <= flags_nxt;
         line_tick  <= pix_en & h_wrap;
         frame_tick <= pix_en & h_wrap & v_wrap;
      end
   end

   assign scan.pix_en     = pix_en;
   assign scan.hCount     = h_cnt;
   assign scan.vCount     = v_cnt;
   assign scan.bright     = flags.bright;
   assign scan.hSync      = flags.h_sync;
   assign scan.vSync      = flags.v_sync;
   assign scan.line_tick  = line_tick;
   assign scan.frame_tick = frame_tick;

endmodule
